mem_bus_responder: RTL and testbench

Responder side of the CPU address/data bus. It decodes the 16-bit address and services CPU read/write requests. HRAM (0xFF80-0xFFFE) and the IE register (0xFFFF) are served internally. The unusable region (0xFEA0-0xFEFF) is absorbed locally. All other addresses are forwarded to an external memory port with an ack handshake and a timeout.

---
 rtl/mem_bus_responder_pkg.sv | 25 ++
 rtl/mem_bus_responder_hram.sv | 25 ++
 rtl/mem_bus_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - address map constants, FSM encoding and decode helper for the bus responder
package mem_bus_responder_pkg;

  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT   = 16'hFFFE;
  localparam logic [15:0] IE_ADDR      = 16'hFFFF;
  localparam logic [15:0] ECHO_BASE    = 16'hE000;
  localparam logic [15:0] ECHO_LIMIT   = 16'hFDFF;
  localparam logic [15:0] UNUSED_BASE  = 16'hFEA0;
  localparam logic [15:0] UNUSED_LIMIT = 16'hFEFF;
  localparam logic [15:0] ECHO_OFFSET  = 16'h2000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXT_WAIT = 2'd1,
    RESP     = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mem_bus_responder_hram.sv
// rtl/mem_bus_responder_hram.sv - 127x8 high RAM, synchronous write and read, contents not reset
module hram_127x8 (
  input  logic       clk,
  input  logic       i_we,
  input  logic       i_re,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [0:126];
  logic [7:0] r_rdata;
  logic       w_in_range;

  // Index 0x7F aliases the IE register and has no storage behind it.
  assign w_in_range = (i_addr != 7'h7F);

  always_ff @(posedge clk) begin
    if (i_we && w_in_range) r_mem[i_addr] <= i_wdata;
    if (i_re && w_in_range) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - CPU bus responder: internal HRAM/IE/unusable handling, external forward with timeout
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_in,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic [7:0]  data_out,
  output logic        ready,
  output logic        bus_err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic [7:0]  ie_out
);

  localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data_out;
  logic             r_err;
  logic             r_resp_hram;
  logic             r_ext_req;
  logic             r_ext_we;
  logic [15:0]      r_ext_addr;
  logic [7:0]       r_ext_wdata;
  logic [7:0]       r_ie;

  logic        w_req, w_conflict, w_is_wr;
  logic        w_is_hram, w_is_ie, w_is_unused, w_is_echo, w_internal;
  logic [15:0] w_ext_addr;
  logic [7:0]  w_hram_rdata;
  logic        w_sample_int, w_sample_ext, w_ext_done, w_timeout, w_cnt_en;

  // A simultaneous read and write is serviced as a write.
  assign w_req       = rd_req | wr_req;
  assign w_conflict  = rd_req & wr_req;
  assign w_is_wr     = wr_req;
  assign w_is_hram   = in_range(addr_bus, HRAM_BASE, HRAM_LIMIT);
  assign w_is_ie     = (addr_bus == IE_ADDR);
  assign w_is_unused = in_range(addr_bus, UNUSED_BASE, UNUSED_LIMIT);
  assign w_is_echo   = in_range(addr_bus, ECHO_BASE, ECHO_LIMIT);
  assign w_internal  = w_is_hram | w_is_ie | w_is_unused;
  assign w_ext_addr  = w_is_echo ? (addr_bus - ECHO_OFFSET) : addr_bus;

  hram_127x8 u_hram (
    .clk     (clk),
    .i_we    (w_sample_int && w_is_hram && w_is_wr),
    .i_re    (w_sample_int && w_is_hram && !w_is_wr),
    .i_addr  (addr_bus[6:0]),
    .i_wdata (data_in),
    .o_rdata (w_hram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sample_int = 1'b0;
    w_sample_ext = 1'b0;
    w_ext_done   = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_sample_int = w_internal;
          w_sample_ext = !w_internal;
          w_state_nxt  = w_internal ? RESP : EXT_WAIT;
        end
      end
      EXT_WAIT: begin
        // An ack arriving on the final timeout cycle still completes cleanly.
        if (ext_ack) begin
          w_ext_done  = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == LP_TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      RESP: w_state_nxt = DONE;
      DONE: if (!w_req) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out  <= 8'h00;
      r_err       <= 1'b0;
      r_resp_hram <= 1'b0;
      r_ext_req   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_addr  <= 16'h0000;
      r_ext_wdata <= 8'h00;
      r_ie        <= 8'h00;
      r_cnt       <= '0;
    end else begin
      if (w_sample_int) begin
        r_err       <= w_conflict;
        r_resp_hram <= w_is_hram && !w_is_wr;
        if (w_is_wr) begin
          r_data_out <= data_in;
          if (w_is_ie) r_ie <= data_in;
        end else if (w_is_ie) begin
          r_data_out <= r_ie;
        end else if (w_is_unused) begin
          r_data_out <= 8'h00;
        end
      end
      if (w_sample_ext) begin
        r_err       <= w_conflict;
        r_resp_hram <= 1'b0;
        r_ext_req   <= 1'b1;
        r_ext_we    <= w_is_wr;
        r_ext_addr  <= w_ext_addr;
        r_ext_wdata <= data_in;
        r_cnt       <= '0;
      end
      if (w_ext_done) begin
        r_ext_req  <= 1'b0;
        r_data_out <= r_ext_we ? r_ext_wdata : ext_rdata;
      end
      if (w_timeout) begin
        r_ext_req  <= 1'b0;
        r_data_out <= 8'hFF;
        r_err      <= 1'b1;
      end
      if (w_cnt_en) r_cnt <= r_cnt + CNT_W'(1);
      // Latch the synchronous HRAM read so data_out holds it after RESP.
      if (r_state == RESP && r_resp_hram) r_data_out <= w_hram_rdata;
    end
  end

  assign ready     = (r_state == RESP);
  assign bus_err   = ready && r_err;
  assign data_out  = (ready && r_resp_hram) ? w_hram_rdata : r_data_out;
  assign ext_req   = r_ext_req;
  assign ext_we    = r_ext_we;
  assign ext_addr  = r_ext_addr;
  assign ext_wdata = r_ext_wdata;
  assign ie_out    = r_ie;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed self-checking bench for mem_bus_responder
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_bus;
  logic [7:0]  data_in;
  logic        rd_req, wr_req;
  logic [7:0]  data_out;
  logic        ready, bus_err, ext_req, ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata, ext_rdata, ie_out;
  logic        ext_ack;

  int checks = 0;
  int failures = 0;
  int ext_req_cycles = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (ext_req === 1'b1) ext_req_cycles++;

  mem_bus_responder #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_in(data_in),
    .rd_req(rd_req), .wr_req(wr_req), .data_out(data_out), .ready(ready),
    .bus_err(bus_err), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack), .ie_out(ie_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    rd_req = rd; wr_req = wr; addr_bus = a; data_in = d;
    step();
  endtask

  task automatic release_req();
    rd_req = 1'b0; wr_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_req = 0; wr_req = 0; addr_bus = 0; data_in = 0; ext_rdata = 0; ext_ack = 0;
    step(); step();
    checks++; if (ready !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL reset_ready_err got=%b%b exp=00", ready, bus_err); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (ext_req !== 1'b0 || ext_we !== 1'b0) begin failures++; $display("FAIL reset_ext_ctl got=%b%b exp=00", ext_req, ext_we); end
    checks++; if (ext_addr !== 16'h0000 || ext_wdata !== 8'h00) begin failures++; $display("FAIL reset_ext_bus got=%h/%h exp=0000/00", ext_addr, ext_wdata); end
    checks++; if (ie_out !== 8'h00) begin failures++; $display("FAIL reset_ie got=%h exp=00", ie_out); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_hram();
    int ext_before;
    ext_before = ext_req_cycles;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL hram_idle_ready got=%b exp=0", ready); end
    request(1'b0, 1'b1, 16'hFF80, 8'hA5);
    checks++; if (ready !== 1'b1 || bus_err !== 1'b0) begin failures++; $display("FAIL hram_wr_ready got=%b%b exp=10", ready, bus_err); end
    rd_req = 1'b0; wr_req = 1'b0;
    step();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL hram_wr_single_pulse got=%b exp=0", ready); end
    step();
    request(1'b1, 1'b0, 16'hFF80, 8'h00);
    checks++; if (ready !== 1'b1 || data_out !== 8'hA5) begin failures++; $display("FAIL hram_rd got ready=%b data=%h exp 1/a5", ready, data_out); end
    release_req();
    checks++; if (ready !== 1'b0 || data_out !== 8'hA5) begin failures++; $display("FAIL hram_rd_hold got ready=%b data=%h exp 0/a5", ready, data_out); end
    checks++; if (ext_req_cycles != ext_before) begin failures++; $display("FAIL hram_no_ext got=%0d exp=%0d", ext_req_cycles, ext_before); end
  endtask

  task automatic test_ie();
    request(1'b0, 1'b1, 16'hFFFF, 8'h1F);
    checks++; if (ie_out !== 8'h1F || ready !== 1'b1) begin failures++; $display("FAIL ie_wr got ie=%h ready=%b exp 1f/1", ie_out, ready); end
    release_req();
    request(1'b1, 1'b0, 16'hFFFF, 8'h00);
    checks++; if (data_out !== 8'h1F || ready !== 1'b1) begin failures++; $display("FAIL ie_rd got data=%h ready=%b exp 1f/1", data_out, ready); end
    release_req();
  endtask

  task automatic test_ext_read();
    request(1'b1, 1'b0, 16'hE123, 8'h00);
    checks++; if (ext_req !== 1'b1 || ext_we !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL ext_rd_req got req=%b we=%b ready=%b exp 1/0/0", ext_req, ext_we, ready); end
    checks++; if (ext_addr !== 16'hC123) begin failures++; $display("FAIL ext_rd_echo_addr got=%h exp=c123", ext_addr); end
    step(); step();
    ext_ack = 1'b1; ext_rdata = 8'h3C;
    step();
    ext_ack = 1'b0; ext_rdata = 8'h00;
    checks++; if (ready !== 1'b1 || data_out !== 8'h3C || bus_err !== 1'b0) begin failures++; $display("FAIL ext_rd_resp got ready=%b data=%h err=%b exp 1/3c/0", ready, data_out, bus_err); end
    checks++; if (ext_req !== 1'b0) begin failures++; $display("FAIL ext_rd_req_drop got=%b exp=0", ext_req); end
    release_req();
  endtask

  task automatic test_timeout();
    int n;
    request(1'b1, 1'b0, 16'h4000, 8'h00);
    checks++; if (ext_addr !== 16'h4000) begin failures++; $display("FAIL tmo_addr got=%h exp=4000", ext_addr); end
    n = 0;
    while (ext_req === 1'b1 && n < 40) begin
      n++;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL tmo_early_ready at cycle %0d got=%b exp=0", n, ready); end
      step();
    end
    checks++; if (n != 15) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=15", n); end
    checks++; if (ready !== 1'b1 || bus_err !== 1'b1 || data_out !== 8'hFF) begin failures++; $display("FAIL tmo_resp got ready=%b err=%b data=%h exp 1/1/ff", ready, bus_err, data_out); end
    release_req();
  endtask

  task automatic test_ack_at_timeout();
    request(1'b1, 1'b0, 16'h5000, 8'h00);
    for (int i = 0; i < 14; i++) step();
    checks++; if (ext_req !== 1'b1) begin failures++; $display("FAIL ack_tmo_still_waiting got=%b exp=1", ext_req); end
    ext_ack = 1'b1; ext_rdata = 8'h42;
    step();
    ext_ack = 1'b0; ext_rdata = 8'h00;
    checks++; if (ready !== 1'b1 || bus_err !== 1'b0 || data_out !== 8'h42) begin failures++; $display("FAIL ack_tmo_resp got ready=%b err=%b data=%h exp 1/0/42", ready, bus_err, data_out); end
    release_req();
  endtask

  task automatic test_ext_write();
    request(1'b0, 1'b1, 16'hFF10, 8'h99);
    checks++; if (ext_req !== 1'b1 || ext_we !== 1'b1 || ext_addr !== 16'hFF10 || ext_wdata !== 8'h99) begin
      failures++; $display("FAIL ext_wr_bus got req=%b we=%b addr=%h wdata=%h exp 1/1/ff10/99", ext_req, ext_we, ext_addr, ext_wdata); end
    ext_ack = 1'b1;
    step();
    ext_ack = 1'b0;
    checks++; if (ready !== 1'b1 || bus_err !== 1'b0) begin failures++; $display("FAIL ext_wr_resp got ready=%b err=%b exp 1/0", ready, bus_err); end
    release_req();
    ext_ack = 1'b1;
    step();
    ext_ack = 1'b0;
    step();
    checks++; if (ready !== 1'b0 || ext_req !== 1'b0) begin failures++; $display("FAIL stray_ack got ready=%b req=%b exp 0/0", ready, ext_req); end
  endtask

  task automatic test_unused_conflict();
    int ext_before;
    ext_before = ext_req_cycles;
    request(1'b0, 1'b1, 16'hFEB0, 8'h77);
    checks++; if (ready !== 1'b1 || ext_req !== 1'b0) begin failures++; $display("FAIL unused_wr got ready=%b req=%b exp 1/0", ready, ext_req); end
    release_req();
    request(1'b1, 1'b0, 16'hFEB0, 8'h00);
    checks++; if (ready !== 1'b1 || data_out !== 8'h00) begin failures++; $display("FAIL unused_rd got ready=%b data=%h exp 1/00", ready, data_out); end
    release_req();
    checks++; if (ext_req_cycles != ext_before) begin failures++; $display("FAIL unused_no_ext got=%0d exp=%0d", ext_req_cycles, ext_before); end
    request(1'b1, 1'b1, 16'hFF81, 8'h55);
    checks++; if (ready !== 1'b1 || bus_err !== 1'b1) begin failures++; $display("FAIL conflict_err got ready=%b err=%b exp 1/1", ready, bus_err); end
    release_req();
    request(1'b1, 1'b0, 16'hFF81, 8'h00);
    checks++; if (data_out !== 8'h55 || bus_err !== 1'b0) begin failures++; $display("FAIL conflict_rd got data=%h err=%b exp 55/0", data_out, bus_err); end
    release_req();
  endtask

  task automatic test_reset_mid();
    request(1'b1, 1'b0, 16'h4000, 8'h00);
    step(); step();
    checks++; if (ext_req !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=1", ext_req); end
    rst = 1'b1;
    #1;
    checks++; if (ext_req !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL rmid_async got req=%b ready=%b exp 0/0", ext_req, ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ready !== 1'b0 || ext_req !== 1'b0) begin failures++; $display("FAIL rmid_hold got ready=%b req=%b exp 0/0", ready, ext_req); end
    end
    checks++; if (ie_out !== 8'h00) begin failures++; $display("FAIL rmid_ie got=%h exp=00", ie_out); end
    rst = 1'b0;
    step();
    checks++; if (ext_req !== 1'b1 || ext_addr !== 16'h4000 || ready !== 1'b0) begin failures++; $display("FAIL rmid_fresh got req=%b addr=%h ready=%b exp 1/4000/0", ext_req, ext_addr, ready); end
    ext_ack = 1'b1; ext_rdata = 8'h12;
    step();
    ext_ack = 1'b0; ext_rdata = 8'h00;
    checks++; if (ready !== 1'b1 || data_out !== 8'h12) begin failures++; $display("FAIL rmid_resp got ready=%b data=%h exp 1/12", ready, data_out); end
    release_req();
  endtask

  initial begin
    test_reset();
    test_hram();
    test_ie();
    test_ext_read();
    test_timeout();
    test_ack_at_timeout();
    test_ext_write();
    test_unused_conflict();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
